// File: rtl/fetch_sequencer.sv
// fetch_sequencer: closes the fetch loop with an external ProgramCounter.
// It selects the next PC and drives it on Address. The PC register has no enable, so the
// PC is held by feeding PCResult back. It latches the fetched instruction into IF/ID,
// with a valid/ready handshake toward decode.
//
// Ports:
//   Clk, Reset          rising-edge clock, asynchronous active-low reset
//   PCResult            current PC from ProgramCounter
//   Instruction         instruction memory read data for PCResult
//   Stall               hazard-unit hold request
//   BranchTaken/Target  taken-branch redirect (one-cycle pulse)
//   Jump/JumpTarget     jump redirect (one-cycle pulse), wins over branch
//   ID_Ready            decode can accept IF/ID contents
//   Address             next PC to ProgramCounter.Address (combinational)
//   IF_Instruction      IF/ID instruction
//   IF_PCPlus4          IF/ID PC+4
//   IF_Valid            IF/ID holds a live instruction
//   FetchCount          instructions delivered into IF/ID (wraps)
module fetch_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD     = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] PCResult,
  input  logic [31:0] Instruction,
  input  logic        Stall,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  input  logic        Jump,
  input  logic [31:0] JumpTarget,
  input  logic        ID_Ready,
  output logic [31:0] Address,
  output logic [31:0] IF_Instruction,
  output logic [31:0] IF_PCPlus4,
  output logic        IF_Valid,
  output logic [31:0] FetchCount
);

  typedef enum logic [1:0] {StBoot, StRun, StHold} state_e;

  state_e      r_state;
  state_e      w_state_next;
  logic        w_hold;
  logic        w_redirect;
  logic        w_load;
  logic        w_flush;
  logic [31:0] w_pc_plus4;
  logic [31:0] r_instr;
  logic [31:0] r_pc_plus4;
  logic        r_valid;
  logic [31:0] r_count;

  // Targets are forced word-aligned; the low bits are intentionally dropped.
  logic w_unused_tgt_lsb;
  assign w_unused_tgt_lsb = ^{JumpTarget[1:0], BranchTarget[1:0]};

  assign w_hold     = Stall | (r_valid & ~ID_Ready);
  assign w_redirect = Jump | BranchTaken;
  assign w_pc_plus4 = PCResult + 32'd4;

  // State register
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state <= StBoot;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StBoot: w_state_next = StRun;
      StRun:  if (w_hold && !w_redirect) w_state_next = StHold;
      StHold: if (!w_hold || w_redirect) w_state_next = StRun;
      default: w_state_next = StBoot;
    endcase
  end

  // Output logic: next PC and IF/ID update controls
  always_comb begin
    Address = RESET_VECTOR;
    w_load  = 1'b0;
    w_flush = 1'b0;
    if (r_state != StBoot) begin
      // Redirects come from a later stage, so they beat stall and backpressure.
      if (Jump) begin
        Address = {JumpTarget[31:2], 2'b00};
        w_flush = 1'b1;
      end else if (BranchTaken) begin
        Address = {BranchTarget[31:2], 2'b00};
        w_flush = 1'b1;
      end else if (w_hold) begin
        Address = PCResult;
      end else begin
        Address = w_pc_plus4;
        w_load  = 1'b1;
      end
    end
  end

  // IF/ID pipeline register and delivery counter
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_instr    <= NOP_WORD;
      r_pc_plus4 <= 32'd0;
      r_valid    <= 1'b0;
      r_count    <= 32'd0;
    end else if (w_flush) begin
      r_instr    <= NOP_WORD;
      r_pc_plus4 <= 32'd0;
      r_valid    <= 1'b0;
    end else if (w_load) begin
      r_instr    <= Instruction;
      r_pc_plus4 <= w_pc_plus4;
      r_valid    <= 1'b1;
      r_count    <= r_count + 32'd1;
    end
  end

  assign IF_Instruction = r_instr;
  assign IF_PCPlus4     = r_pc_plus4;
  assign IF_Valid       = r_valid;
  assign FetchCount     = r_count;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed table-driven bench for fetch_sequencer with a behavioural ProgramCounter
// and an instruction memory where mem[PC] = PC*16.
module tb_fetch_sequencer;

  logic        Clk;
  logic        Reset;
  logic [31:0] PCResult;
  logic [31:0] Instruction;
  logic        Stall;
  logic        BranchTaken;
  logic [31:0] BranchTarget;
  logic        Jump;
  logic [31:0] JumpTarget;
  logic        ID_Ready;
  logic [31:0] Address;
  logic [31:0] IF_Instruction;
  logic [31:0] IF_PCPlus4;
  logic        IF_Valid;
  logic [31:0] FetchCount;

  int n_vec;
  int n_fail;

  fetch_sequencer #(
    .RESET_VECTOR(32'h0000_0000),
    .NOP_WORD    (32'h0000_0000)
  ) dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .PCResult      (PCResult),
    .Instruction   (Instruction),
    .Stall         (Stall),
    .BranchTaken   (BranchTaken),
    .BranchTarget  (BranchTarget),
    .Jump          (Jump),
    .JumpTarget    (JumpTarget),
    .ID_Ready      (ID_Ready),
    .Address       (Address),
    .IF_Instruction(IF_Instruction),
    .IF_PCPlus4    (IF_PCPlus4),
    .IF_Valid      (IF_Valid),
    .FetchCount    (FetchCount)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // ProgramCounter: plain register, no enable.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) PCResult <= 32'd0;
    else        PCResult <= Address;
  end

  assign Instruction = {PCResult[27:0], 4'b0000};

  typedef struct {
    logic        stall;
    logic        br;
    logic [31:0] brt;
    logic        jmp;
    logic [31:0] jt;
    logic        rdy;
    logic [31:0] e_addr;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic [31:0] e_pc4;
    logic        e_valid;
    logic [31:0] e_cnt;
  } vec_t;

  localparam int NVec = 19;
  vec_t vecs[NVec];

  function automatic vec_t mk(input logic stall, input logic br, input logic [31:0] brt,
                              input logic jmp, input logic [31:0] jt, input logic rdy,
                              input logic [31:0] e_addr, input logic [31:0] e_pc,
                              input logic [31:0] e_instr, input logic [31:0] e_pc4,
                              input logic e_valid, input logic [31:0] e_cnt);
    vec_t v;
    v.stall = stall; v.br = br; v.brt = brt; v.jmp = jmp; v.jt = jt; v.rdy = rdy;
    v.e_addr = e_addr; v.e_pc = e_pc; v.e_instr = e_instr; v.e_pc4 = e_pc4;
    v.e_valid = e_valid; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk_ifid(input string tag, input logic [31:0] instr, input logic [31:0] pc4,
                          input logic valid, input logic [31:0] cnt);
    chk({tag, " IF_Instruction"}, IF_Instruction, instr);
    chk({tag, " IF_PCPlus4"}, IF_PCPlus4, pc4);
    chk({tag, " IF_Valid"}, {31'd0, IF_Valid}, {31'd0, valid});
    chk({tag, " FetchCount"}, FetchCount, cnt);
  endtask

  initial begin
    n_vec  = 0;
    n_fail = 0;
    //            stall br brt         jmp jt           rdy addr         pc           instr        pc4          v cnt
    vecs[0]  = mk(0, 0, 0,          0, 0,            1, 32'h0,        32'h0,       32'h0,       32'h0,       0, 0); // BOOT
    vecs[1]  = mk(0, 0, 0,          0, 0,            1, 32'h4,        32'h4,       32'h0,       32'h4,       1, 1);
    vecs[2]  = mk(0, 0, 0,          0, 0,            1, 32'h8,        32'h8,       32'h40,      32'h8,       1, 2);
    vecs[3]  = mk(1, 0, 0,          0, 0,            1, 32'h8,        32'h8,       32'h40,      32'h8,       1, 2); // stall
    vecs[4]  = mk(1, 0, 0,          0, 0,            1, 32'h8,        32'h8,       32'h40,      32'h8,       1, 2);
    vecs[5]  = mk(1, 0, 0,          0, 0,            1, 32'h8,        32'h8,       32'h40,      32'h8,       1, 2);
    vecs[6]  = mk(0, 0, 0,          0, 0,            1, 32'hC,        32'hC,       32'h80,      32'hC,       1, 3);
    vecs[7]  = mk(0, 1, 32'h43,     0, 0,            1, 32'h40,       32'h40,      32'h0,       32'h0,       0, 3); // branch
    vecs[8]  = mk(0, 0, 0,          0, 0,            1, 32'h44,       32'h44,      32'h400,     32'h44,      1, 4);
    vecs[9]  = mk(1, 1, 32'h40,     1, 32'h100,      1, 32'h100,      32'h100,     32'h0,       32'h0,       0, 4); // jump wins
    vecs[10] = mk(0, 0, 0,          0, 0,            1, 32'h104,      32'h104,     32'h1000,    32'h104,     1, 5);
    vecs[11] = mk(0, 0, 0,          0, 0,            0, 32'h104,      32'h104,     32'h1000,    32'h104,     1, 5); // backpressure
    vecs[12] = mk(0, 0, 0,          0, 0,            0, 32'h104,      32'h104,     32'h1000,    32'h104,     1, 5);
    vecs[13] = mk(0, 0, 0,          0, 0,            1, 32'h108,      32'h108,     32'h1040,    32'h108,     1, 6);
    vecs[14] = mk(0, 0, 0,          1, 32'hFFFFFFFF, 1, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'h0,      32'h0,       0, 6);
    vecs[15] = mk(0, 0, 0,          0, 0,            1, 32'h0,        32'h0,       32'hFFFFFFC0, 32'h0,      1, 7); // wrap
    vecs[16] = mk(0, 1, 32'h200,    0, 0,            0, 32'h200,      32'h200,     32'h0,       32'h0,       0, 7); // branch vs bp
    vecs[17] = mk(0, 0, 0,          0, 0,            0, 32'h204,      32'h204,     32'h2000,    32'h204,     1, 8);
    vecs[18] = mk(0, 0, 0,          0, 0,            1, 32'h208,      32'h208,     32'h2040,    32'h208,     1, 9);

    Reset = 1'b0; Stall = 1'b0; BranchTaken = 1'b0; BranchTarget = '0;
    Jump = 1'b0; JumpTarget = '0; ID_Ready = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    chk("reset Address", Address, 32'h0);
    chk_ifid("reset", 32'h0, 32'h0, 1'b0, 32'h0);
    Reset = 1'b1;

    for (int i = 0; i < NVec; i++) begin
      Stall = vecs[i].stall; BranchTaken = vecs[i].br; BranchTarget = vecs[i].brt;
      Jump = vecs[i].jmp; JumpTarget = vecs[i].jt; ID_Ready = vecs[i].rdy;
      #1;
      chk($sformatf("v%0d Address", i), Address, vecs[i].e_addr);
      @(posedge Clk);
      #1;
      chk($sformatf("v%0d PCResult", i), PCResult, vecs[i].e_pc);
      chk_ifid($sformatf("v%0d", i), vecs[i].e_instr, vecs[i].e_pc4, vecs[i].e_valid,
               vecs[i].e_cnt);
    end

    Stall = 1'b0; BranchTaken = 1'b0; Jump = 1'b0; ID_Ready = 1'b1;
    #1;
    chk("pre-reset Address", Address, 32'h20C);
    // Mid-operation asynchronous reset, between clock edges.
    Reset = 1'b0;
    #1;
    chk("async reset Address", Address, 32'h0);
    chk_ifid("async reset", 32'h0, 32'h0, 1'b0, 32'h0);
    @(posedge Clk);
    #1;
    chk_ifid("in reset", 32'h0, 32'h0, 1'b0, 32'h0);
    Reset = 1'b1;
    #1;
    chk("reboot Address", Address, 32'h0);
    @(posedge Clk);
    #1;
    chk("reboot PCResult", PCResult, 32'h0);
    chk_ifid("reboot edge1", 32'h0, 32'h0, 1'b0, 32'h0);
    chk("reboot next Address", Address, 32'h4);
    @(posedge Clk);
    #1;
    chk("reboot edge2 PCResult", PCResult, 32'h4);
    chk_ifid("reboot edge2", 32'h0, 32'h4, 1'b1, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Drives the ProgramCounter's Address input and consumes its PCResult output. Together they close the fetch loop.
- Selects the next PC from sequential, branch, jump and hold sources.
- Latches the fetched instruction into an IF/ID pipeline register, with a valid/ready handshake toward decode.
- The ProgramCounter has no write enable, so this block holds the PC by feeding PCResult back as Address.

Parameters:
RESET_VECTOR, 32'h00000000, first fetch address after reset release
NOP_WORD, 32'h00000000, instruction value loaded into IF/ID on flush/reset

Ports:
Clk  input  1  system clock, rising-edge
Reset  input  1  asynchronous, active-low reset
PCResult  input  32  current PC from ProgramCounter
Instruction  input  32  instruction memory read data for PCResult (combinational read)
Stall  input  1  hazard-unit hold request
BranchTaken  input  1  resolved taken branch, one-cycle pulse
BranchTarget  input  32  branch destination
Jump  input  1  jump request, one-cycle pulse
JumpTarget  input  32  jump destination
ID_Ready  input  1  decode stage can accept IF/ID contents
Address  output  32  next PC, wired to ProgramCounter.Address
IF_Instruction  output  32  registered instruction
IF_PCPlus4  output  32  registered PCResult+4
IF_Valid  output  1  IF/ID register holds a live instruction
FetchCount  output  32  count of instructions delivered into IF/ID

Behaviour:
- Reset=0, asynchronous and effective immediately, also mid-operation:
  - state=BOOT
  - IF_Instruction=NOP_WORD, IF_PCPlus4=0, IF_Valid=0, FetchCount=0
  - Address=RESET_VECTOR
- FSM states BOOT, RUN, HOLD:
  - BOOT: Address=RESET_VECTOR; IF/ID is not loaded. Lasts exactly one clock edge after Reset rises, then goes to RUN.
  - hold condition H = Stall | (IF_Valid & ~ID_Ready).
  - RUN → HOLD on an edge where H=1 and there is no redirect.
  - HOLD → RUN on an edge where H=0 or a redirect is present.
- Address is combinational. Priority, highest first:
  1. BOOT: RESET_VECTOR.
  2. Jump: {JumpTarget[31:2],2'b00}.
  3. BranchTaken: {BranchTarget[31:2],2'b00}.
  4. H=1: PCResult (PC holds).
  5. Otherwise: PCResult+32'd4.
- Jump and BranchTaken asserted together: Jump wins and the branch is dropped.
- A redirect overrides Stall and backpressure, because it comes from a later stage and squashes younger work.
- PC+4 is modulo 2^32: 32'hFFFFFFFC → 32'h00000000, with no flag.
- IF/ID register update at the rising edge:
  - BOOT: stays at NOP_WORD / 0 / 0.
  - Redirect (Jump | BranchTaken): IF_Instruction=NOP_WORD, IF_PCPlus4=0, IF_Valid=0. This is a one-cycle bubble.
  - H=1, no redirect: all IF/ID outputs retain their value.
  - Otherwise: IF_Instruction=Instruction, IF_PCPlus4=PCResult+4, IF_Valid=1.
- Handshake: a transfer to decode occurs on an edge with IF_Valid=1 and ID_Ready=1. IF_Valid stays high while ID_Ready=0, and contents are stable until accepted.
- FetchCount increments by 1 on each edge that loads IF/ID with IF_Valid=1. It wraps from 32'hFFFFFFFF to 0.
- Latency: an instruction at PC appears on IF_Instruction one edge after PCResult=PC.
- First valid fetch after reset: edge 1 loads the PC with RESET_VECTOR; edge 2 loads IF/ID.
- No combinational path from ID_Ready or Stall to IF_* outputs. Address may depend combinationally on all inputs.

Test Plan:
- Reset held low for 2 cycles, then released; Instruction=mem[PC] with mem[i]=i*16:
  - Address=0 during BOOT.
  - PCResult goes 0, 4, 8, 12 on successive edges.
  - IF_Instruction goes 0, 64, 128; IF_PCPlus4 goes 4, 8, 12.
  - FetchCount goes 1, 2, 3.
- Stall=1 for 3 cycles at PCResult=8:
  - Address=8 and the PC holds at 8.
  - IF/ID is frozen.
  - FetchCount is unchanged.
  - On release, PCResult goes 12.
- BranchTaken=1 with BranchTarget=32'h40 (also try 32'h43) at PCResult=12:
  - The next edge gives PCResult=0x40 and IF_Valid=0 (bubble).
  - The following edge gives IF_PCPlus4=0x44.
- Jump=1 (JumpTarget=0x100) and BranchTaken=1 (BranchTarget=0x40), with Stall=1, all in the same cycle:
  - PCResult=0x100.
  - IF_Valid=0.
- ID_Ready=0 for 2 cycles while IF_Valid=1:
  - IF outputs are stable and PC holds.
  - When ID_Ready=1, exactly one transfer occurs and fetch resumes.
- Wrap and mid-operation reset:
  - With PCResult=32'hFFFFFFFC, the next PC is 0.
  - Drive Reset low between clock edges: all IF/ID outputs and FetchCount go to 0 immediately, and Address=RESET_VECTOR.
